// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, defaults and width helper for the single-clock FIFO
package fifo_pkg;

    typedef enum logic {
        FIFO_REG_READ = 1'b0,
        FIFO_FWFT     = 1'b1
    } fifo_mode_e;

    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_ADDR_WIDTH = 4;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// rtl/sync_fifo_flex_if.sv - producer/consumer/control bundle of the single-clock FIFO
interface sync_fifo_flex_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
);
    logic                  w_inc;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_full;
    logic                  w_almost_full;
    logic                  r_inc;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic [ADDR_WIDTH:0]   fill_count;
    logic [ADDR_WIDTH:0]   af_level;
    logic [ADDR_WIDTH:0]   ae_level;
    logic                  flush;
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_inc, w_data, r_inc, af_level, ae_level, flush, err_clr,
        input  w_full, w_almost_full, r_data, r_empty, r_almost_empty,
               fill_count, overflow, underflow
    );

    modport slave (
        input  w_inc, w_data, r_inc, af_level, ae_level, flush, err_clr,
        output w_full, w_almost_full, r_data, r_empty, r_almost_empty,
               fill_count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem_1clk.sv
// rtl/fifo_mem_1clk.sv - flop-array storage, synchronous write and asynchronous read
module fifo_mem_1clk #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with occupancy, thresholds, flush, sticky errors, FWFT option
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH,
    parameter int FWFT       = 0
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_flex_if.slave bus
);
    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam int         CW    = count_width(DEPTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_REG_READ;

    logic [CW-1:0]         r_wptr;
    logic [CW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [CW-1:0]         w_count_nxt;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Flush discards both requests and suppresses error reporting for that cycle
    assign w_wr_acc  = bus.w_inc && !r_full  && !bus.flush;
    assign w_rd_acc  = bus.r_inc && !r_empty && !bus.flush;
    assign w_ovf_set = bus.w_inc &&  r_full  && !bus.flush;
    assign w_udf_set = bus.r_inc &&  r_empty && !bus.flush;

    always_comb begin
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_count_nxt = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else if (bus.flush) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + CW'(1);
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CW'(DEPTH));
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= bus.af_level);
            r_aempty <= (w_count_nxt <= bus.ae_level);
        end
    end

    // A new error in the same cycle as err_clr must survive the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr);
            r_udf <= w_udf_set | (r_udf & ~bus.err_clr);
        end
    end

    fifo_mem_1clk #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (bus.w_data),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign bus.r_data = r_empty ? '0 : w_mem_rdata;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rdata;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_rd_acc) begin
                    r_rdata <= w_mem_rdata;
                end
            end

            assign bus.r_data = r_rdata;
        end
    endgenerate

    assign bus.w_full         = r_full;
    assign bus.w_almost_full  = r_afull;
    assign bus.r_empty        = r_empty;
    assign bus.r_almost_empty = r_aempty;
    assign bus.fill_count     = r_count;
    assign bus.overflow       = r_ovf;
    assign bus.underflow      = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - bench driving registered-read and FWFT instances against a queue model
module tb_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          w_inc;
    logic [DW-1:0] w_data;
    logic          r_inc;
    logic [AW:0]   af_level;
    logic [AW:0]   ae_level;
    logic          flush;
    logic          err_clr;

    int n_assert;
    int n_fail;

    logic [7:0] q[$];
    logic       m_ovf;
    logic       m_udf;
    logic       m_af;
    logic       m_ae;
    logic [7:0] m_rdata;

    sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
    sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

    assign if0.w_inc    = w_inc;
    assign if0.w_data   = w_data;
    assign if0.r_inc    = r_inc;
    assign if0.af_level = af_level;
    assign if0.ae_level = ae_level;
    assign if0.flush    = flush;
    assign if0.err_clr  = err_clr;
    assign if1.w_inc    = w_inc;
    assign if1.w_data   = w_data;
    assign if1.r_inc    = r_inc;
    assign if1.af_level = af_level;
    assign if1.ae_level = ae_level;
    assign if1.flush    = flush;
    assign if1.err_clr  = err_clr;

    sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_af    = 1'b0;
        m_ae    = 1'b1;
        m_rdata = '0;
    endtask

    // One clock edge of the FIFO behaviour, using pre-edge occupancy for accept decisions
    task automatic model_edge();
        bit full, empty, ovf_set, udf_set;
        full    = (q.size() == DEPTH);
        empty   = (q.size() == 0);
        ovf_set = 0;
        udf_set = 0;
        if (flush) begin
            q.delete();
            m_af = 1'b0;
            m_ae = 1'b1;
        end else begin
            ovf_set = w_inc && full;
            udf_set = r_inc && empty;
            if (r_inc && !empty) m_rdata = q.pop_front();
            if (w_inc && !full)  q.push_back(w_data);
            m_af = (q.size() >= int'(af_level));
            m_ae = (q.size() <= int'(ae_level));
        end
        m_ovf = ovf_set || (m_ovf && !err_clr);
        m_udf = udf_set || (m_udf && !err_clr);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":count0"}, 32'(if0.fill_count), q.size());
        chk({tag, ":full0"},  32'(if0.w_full), (q.size() == DEPTH));
        chk({tag, ":empty0"}, 32'(if0.r_empty), (q.size() == 0));
        chk({tag, ":af0"},    32'(if0.w_almost_full), m_af);
        chk({tag, ":ae0"},    32'(if0.r_almost_empty), m_ae);
        chk({tag, ":ovf0"},   32'(if0.overflow), m_ovf);
        chk({tag, ":udf0"},   32'(if0.underflow), m_udf);
        chk({tag, ":rdata0"}, 32'(if0.r_data), m_rdata);
        chk({tag, ":count1"}, 32'(if1.fill_count), q.size());
        chk({tag, ":empty1"}, 32'(if1.r_empty), (q.size() == 0));
        chk({tag, ":full1"},  32'(if1.w_full), (q.size() == DEPTH));
        chk({tag, ":ovf1"},   32'(if1.overflow), m_ovf);
        chk({tag, ":udf1"},   32'(if1.underflow), m_udf);
        if (q.size() != 0) chk({tag, ":head1"}, 32'(if1.r_data), q[0]);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle();
        w_inc   = 1'b0;
        r_inc   = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        w_data   = '0;
        af_level = 5'd14;
        ae_level = 5'd2;
        idle();
        model_reset();

        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Fill 0x00..0x0F, then a rejected 17th write
        for (int i = 0; i < DEPTH; i++) begin
            w_inc  = 1'b1;
            w_data = 8'(i);
            cyc("fill");
        end
        chk("fill_full", 32'(if0.w_full), 1);
        w_data = 8'hAA;
        cyc("overflow_write");
        chk("ovf_count", 32'(if0.fill_count), 16);
        chk("ovf_flag", 32'(if0.overflow), 1);
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            r_inc = 1'b1;
            cyc("drain");
            chk("drain_data", 32'(if0.r_data), i);
        end
        cyc("read_empty_sets_udf");
        chk("udf_flag", 32'(if0.underflow), 1);
        idle();

        err_clr = 1'b1;
        cyc("err_clr");
        r_inc = 1'b1;
        cyc("udf_then_clr");
        cyc("clr_with_new_udf");
        chk("set_wins", 32'(if0.underflow), 1);
        r_inc = 1'b0;
        cyc("err_clr2");
        idle();

        // Hold occupancy at 8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            w_inc  = 1'b1;
            w_data = 8'($urandom);
            cyc("to8");
        end
        r_inc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w_data = 8'($urandom);
            cyc("simul8");
        end
        chk("simul_count8", 32'(if0.fill_count), 8);
        r_inc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_data = 8'($urandom);
            cyc("to_full");
        end
        r_inc  = 1'b1;
        w_data = 8'hBB;
        cyc("full_wr_rd");
        chk("full_wr_rd_count", 32'(if0.fill_count), 15);
        chk("full_wr_rd_ovf", 32'(if0.overflow), 1);
        w_inc = 1'b0;
        for (int i = 0; i < 15; i++) cyc("drain2");
        idle();

        // FWFT head presentation without a read
        w_inc  = 1'b1;
        w_data = 8'h5A;
        cyc("fwft_write");
        w_inc = 1'b0;
        cyc("fwft_hold");
        chk("fwft_head", 32'(if1.r_data), 8'h5A);
        r_inc = 1'b1;
        cyc("fwft_pop");
        chk("fwft_empty", 32'(if1.r_empty), 1);
        idle();

        // Flush at count 9 overrides a concurrent write
        for (int i = 0; i < 9; i++) begin
            w_inc  = 1'b1;
            w_data = 8'($urandom);
            cyc("to9");
        end
        flush  = 1'b1;
        w_data = 8'hEE;
        cyc("flush");
        chk("flush_count", 32'(if0.fill_count), 0);
        chk("flush_ovf_kept", 32'(if0.overflow), 1);
        flush  = 1'b0;
        w_data = 8'h33;
        cyc("post_flush_w1");
        w_data = 8'h44;
        cyc("post_flush_w2");
        w_inc = 1'b0;
        r_inc = 1'b1;
        cyc("post_flush_rd");
        chk("post_flush_first", 32'(if0.r_data), 8'h33);
        idle();

        // Random traffic, write-heavy then read-heavy to reach both boundaries
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp      = (i < 200) ? 3 : 1;
            w_inc   = ($urandom_range(0, 3) < wp);
            r_inc   = ($urandom_range(0, 3) < (4 - wp));
            w_data  = 8'($urandom);
            flush   = ($urandom_range(0, 47) == 0);
            err_clr = !flush && ($urandom_range(0, 15) == 0);
            cyc("random");
        end
        idle();

        // Asynchronous reset in the middle of a burst
        w_inc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_data = 8'($urandom);
            cyc("burst");
        end
        #2;
        rst = 1'b1;
        #1;
        idle();
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b0;
        w_inc  = 1'b1;
        w_data = 8'h77;
        cyc("after_rst_w");
        w_inc = 1'b0;
        r_inc = 1'b1;
        cyc("after_rst_r");
        chk("after_rst_data", 32'(if0.r_data), 8'h77);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock, parametrised successor to the dual-clock FIFO top, used where producer and consumer share a clock.
- Adds an occupancy count and programmable almost-full/almost-empty thresholds.
- Adds a synchronous flush, sticky overflow/underflow error flags, and a selectable read mode: registered-read or first-word-fall-through (FWFT).
- Sits between a stream producer and consumer inside one clock domain. It is also the building block for the planned multi-channel buffering.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words (default 16)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented on r_data whenever not empty

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
w_inc  in  1  write request
w_data  in  DATA_WIDTH  write data
w_full  out  1  FIFO full
w_almost_full  out  1  fill_count >= af_level
r_inc  in  1  read request
r_data  out  DATA_WIDTH  read data
r_empty  out  1  FIFO empty
r_almost_empty  out  1  fill_count <= ae_level
fill_count  out  ADDR_WIDTH+1  words currently stored, 0..DEPTH
af_level  in  ADDR_WIDTH+1  almost-full threshold, quasi-static
ae_level  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static
flush  in  1  synchronous flush pulse
err_clr  in  1  clears sticky error flags
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - w_full=0, w_almost_full=0, r_empty=1, r_almost_empty=1.
  - fill_count=0, overflow=0, underflow=0, r_data=0.
  - Pointers are 0; memory contents are not reset.
- Pointers: binary, ADDR_WIDTH+1 bits each. The MSB is the wrap bit; the address is the low ADDR_WIDTH bits. They wrap naturally modulo 2*DEPTH.
- Accept rules, using flag values registered at the current edge:
  - write accepted iff w_inc && !w_full
  - read accepted iff r_inc && !r_empty
- Flag and count update:
  - All flags and fill_count are registered and computed from the next-state count.
  - A write at edge N makes r_empty=0 visible after edge N. No synchronizer delay.
- Simultaneous accepted write and read: count unchanged, both pointers advance. Legal at any fill level except as below.
- Full with w_inc && r_inc: the read is accepted, the write is rejected, and overflow is set. There is no write-through.
- Empty with w_inc && r_inc: the write is accepted, the read is rejected, and underflow is set. In FWFT mode the new word still appears next cycle.
- Threshold flags: w_almost_full = (count >= af_level); r_almost_empty = (count <= ae_level). Unsigned compare at ADDR_WIDTH+1 bits. af_level > DEPTH means never asserted.
- FWFT=0:
  - On an accepted read, r_data <= mem[r_addr] at that edge (latency 1).
  - r_data holds its value otherwise.
- FWFT=1:
  - r_data = mem[r_addr] combinationally from the flop array while !r_empty; r_inc pops.
  - r_data is don't-care while empty, and the bench must not check it.
- flush:
  - At the edge it is sampled, pointers and count clear and flags take their reset values.
  - It overrides any concurrent write or read: both are discarded and no error is flagged.
  - Error flags are unaffected by flush.
- Sticky errors: set on the offending cycle and held until err_clr. If set and err_clr occur in the same cycle, set wins.
- Reset mid-operation: all state returns immediately to reset values, asynchronously. Deassertion must be synchronised externally.

Decomposition:
- fifo_pkg:
  - typedef fifo_mode_e {FIFO_REG_READ, FIFO_FWFT}
  - function clog2-based count-width helper
  - localparam default widths
- One sub-module, fifo_mem_1clk: flop array with a synchronous write port and an asynchronous read port, parameterised by DATA_WIDTH/ADDR_WIDTH.
- Pointer, count, flag and error logic stay in sync_fifo_flex.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, af_level=14, ae_level=2):
- Fill/drain, FWFT=0: write 0x00..0x0F on 16 cycles. Expect w_full=1 after the 16th edge, fill_count=16, w_almost_full from count 14. Then 16 reads return 0x00..0x0F one cycle after each r_inc, and r_empty=1 after the last.
- Overflow/underflow: at full, a 17th write (0xAA) leaves count 16 and sets overflow; the data read later excludes 0xAA. When empty, r_inc sets underflow. err_clr clears both; err_clr coincident with a new underflow keeps underflow=1.
- Simultaneous: at count 8, 20 cycles of w_inc&&r_inc keep fill_count=8 while data stays in order across pointer wrap. At full, w_inc&&r_inc drops to count 15 with overflow=1.
- FWFT=1: write 0x5A into an empty FIFO. Next cycle r_empty=0 and r_data=0x5A with no r_inc; r_inc then gives r_empty=1.
- Flush: at count 9, flush with w_inc gives count 0, r_empty=1, r_almost_empty=1, overflow/underflow unchanged; the next write 0x33 is read first.
- Async reset: assert rst mid-burst between clock edges. Outputs go to reset values immediately, before the next edge.
